ps2_host_rx: RTL and testbench

- Host-side PS/2 receiver: the consumer end of the emulated keyboard/mouse lines (ps2_kbd_clk/ps2_kbd_data, ps2_mouse_clk/ps2_mouse_data) that mist_io drives toward the core.
- Deserialises 11-bit device-to-host frames and checks parity and stop bit.
- Buffers good bytes in a read-handshake FIFO.
- Decodes set-2 scan-code prefixes (E0/F0) into single key events for the Spectrum keyboard matrix logic.

---
 rtl/ps2_host_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_host_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises and deglitches the line, deserialises 11-bit frames,
// buffers good bytes in a FIFO and folds E0/F0 prefixes into single key events.
module ps2_host_rx #(
  parameter int unsigned FILTER    = 4,
  parameter int unsigned TIMEOUT   = 4000,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release
);

  localparam int unsigned Depth = 2 ** FIFO_BITS;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Line conditioning
  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic       filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       fall;

  // Frame FSM
  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              good_q, good_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              stop_bad;

  // FIFO
  logic [7:0]        mem_q [Depth];
  logic [FIFO_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic              empty, full, pop, push;
  logic              ovf_q, ovf_d;

  // Key decoder
  logic       ext_q, ext_d, rel_q, rel_d;
  logic       kstb_q, kstb_d;
  logic [7:0] kcode_q, kcode_d;
  logic       kext_q, kext_d, krel_q, krel_d;

  // A level change is accepted only after FILTER consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == 4'(FILTER - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    good_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    stop_bad  = 1'b0;
    if (state_q != StIdle) begin
      tmo_d = tmo_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (fall && !dat_s2_q) begin
          state_d   = StData;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          tmo_d     = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat_s2_q;
          tmo_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          tmo_d   = '0;
          if (!dat_s2_q) begin
            ferr_d   = 1'b1;
            stop_bad = 1'b1;
          end else if (^{shift_q, par_q}) begin
            good_d = 1'b1;
          end else begin
            perr_d   = 1'b1;
            stop_bad = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // An edge in the same cycle as expiry counts as progress, not an abort.
    if (state_q != StIdle && !fall && tmo_q == TmoW'(TIMEOUT - 1)) begin
      state_d = StIdle;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end
  end

  // The completed byte stays in shift_q while IDLE, so good_q can write it directly.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
                 (wptr_q[FIFO_BITS-1:0] == rptr_q[FIFO_BITS-1:0]);
  assign pop   = rd && !empty;
  assign push  = good_q && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = good_q && full && !pop;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_comb begin
    ext_d   = ext_q;
    rel_d   = rel_q;
    kstb_d  = 1'b0;
    kcode_d = kcode_q;
    kext_d  = kext_q;
    krel_d  = krel_q;
    if (good_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        kstb_d  = 1'b1;
        kcode_d = shift_q;
        kext_d  = ext_q;
        krel_d  = rel_q;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
      end
    end
    if (stop_bad) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      good_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      kstb_q    <= 1'b0;
      kcode_q   <= '0;
      kext_q    <= 1'b0;
      krel_q    <= 1'b0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      good_q    <= good_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      kstb_q    <= kstb_d;
      kcode_q   <= kcode_d;
      kext_q    <= kext_d;
      krel_q    <= krel_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem_q[wptr_q[FIFO_BITS-1:0]] <= shift_q;
    end
  end

  assign valid       = !empty;
  assign dout        = valid ? mem_q[rptr_q[FIFO_BITS-1:0]] : 8'h00;
  assign overflow    = ovf_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign key_strobe  = kstb_q;
  assign key_code    = kcode_q;
  assign key_ext     = kext_q;
  assign key_release = krel_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Scoreboard bench for ps2_host_rx: stimulus pushes expected bytes/events, a negedge monitor
// pops and compares whenever the DUT presents a read, key strobe or error pulse.
module tb_ps2_host_rx;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid, overflow, parity_err, frame_err, key_strobe, key_ext, key_release;
  logic [7:0] key_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_fifo[$];
  logic [9:0] exp_key[$];
  int         exp_evt[$];  // 1 overflow, 2 parity_err, 3 frame_err

  ps2_host_rx dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd         (rd),
    .dout       (dout),
    .valid      (valid),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  task automatic chk_evt(input int code);
    if (exp_evt.size() == 0) unexpected("error_pulse", code);
    else chk("error_pulse", code, exp_evt.pop_front());
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (rd && valid) begin
        if (exp_fifo.size() == 0) unexpected("fifo_pop", dout);
        else chk("fifo_dout", dout, exp_fifo.pop_front());
      end
      if (key_strobe) begin
        if (exp_key.size() == 0) unexpected("key_event", {key_code, key_ext, key_release});
        else chk("key_event", {key_code, key_ext, key_release}, exp_key.pop_front());
      end
      if (overflow)   chk_evt(1);
      if (parity_err) chk_evt(2);
      if (frame_err)  chk_evt(3);
    end
  end

  // One bit cell; optionally pulses rd in the cycle the stop-bit byte is written.
  task automatic ps2_bit(input logic b, input bit rd_at_write = 1'b0);
    ps2_data = b;
    repeat (15) @(posedge clk_sys);
    #1 ps2_clk = 1'b0;
    if (rd_at_write) begin
      repeat (6) @(posedge clk_sys);
      #1 rd = 1'b1;
      @(posedge clk_sys);
      #1 rd = 1'b0;
      repeat (13) @(posedge clk_sys);
    end else begin
      repeat (20) @(posedge clk_sys);
    end
    #1 ps2_clk = 1'b1;
    repeat (5) @(posedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit rd_w = 1'b0);
    logic p;
    p = ~(^b);
    if (bad_par) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1, rd_w);
    ps2_data = 1'b1;
  endtask

  task automatic rd_pulse();
    @(posedge clk_sys);
    #1 rd = 1'b1;
    @(posedge clk_sys);
    #1 rd = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    chk("reset_outputs", {dout, valid, overflow, parity_err, frame_err, key_strobe,
                          key_code, key_ext, key_release}, 32'h0);
    #1 reset_n = 1'b1;
    wait_cyc(5);

    // Single frame 0x1C
    exp_fifo.push_back(8'h1C);
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C);
    wait_cyc(5);
    chk("t1_valid", valid, 1);
    chk("t1_dout", dout, 8'h1C);
    rd_pulse();
    wait_cyc(2);
    chk("t1_empty", valid, 0);
    rd_pulse();  // pop on empty must be ignored
    wait_cyc(2);
    chk("t1_rd_empty", valid, 0);

    // E0 F0 75 -> one extended break event
    exp_fifo.push_back(8'hE0);
    exp_fifo.push_back(8'hF0);
    exp_fifo.push_back(8'h75);
    exp_key.push_back({8'h75, 1'b1, 1'b1});
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
    wait_cyc(5);
    repeat (3) rd_pulse();
    wait_cyc(2);
    chk("t2_empty", valid, 0);

    // Parity error clears a pending F0 prefix
    exp_fifo.push_back(8'hF0);
    send_frame(8'hF0);
    exp_evt.push_back(2);
    send_frame(8'h1C, 1'b1);
    wait_cyc(5);
    chk("t3_fifo_only_f0", dout, 8'hF0);
    exp_fifo.push_back(8'h1C);
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C);
    wait_cyc(5);
    repeat (2) rd_pulse();
    wait_cyc(2);
    chk("t3_empty", valid, 0);

    // Overflow on the 9th byte
    for (int b = 1; b <= 9; b++) begin
      if (b <= 8) exp_fifo.push_back(8'(b));
      else exp_evt.push_back(1);
      exp_key.push_back({8'(b), 1'b0, 1'b0});
      send_frame(8'(b));
    end
    wait_cyc(5);
    chk("t4_head", dout, 8'h01);
    repeat (8) rd_pulse();
    wait_cyc(2);
    chk("t4_drained", valid, 0);

    // Same, but pop coincides with the 9th write
    for (int b = 1; b <= 9; b++) begin
      exp_fifo.push_back(8'(b));
      exp_key.push_back({8'(b), 1'b0, 1'b0});
      send_frame(8'(b), 1'b0, b == 9);
    end
    wait_cyc(5);
    chk("t4_head_after_pop", dout, 8'h02);
    repeat (8) rd_pulse();
    wait_cyc(2);
    chk("t4_drained2", valid, 0);

    // Timeout after start + 3 data bits
    exp_evt.push_back(3);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    wait_cyc(4100);
    chk("t5_no_byte", valid, 0);
    exp_fifo.push_back(8'h2A);
    exp_key.push_back({8'h2A, 1'b0, 1'b0});
    send_frame(8'h2A);
    wait_cyc(5);
    chk("t5_dout", dout, 8'h2A);
    rd_pulse();

    // Short low glitch with data low must not start a frame
    @(posedge clk_sys);
    #1 ps2_data = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    #1 ps2_clk = 1'b1;
    wait_cyc(10);
    ps2_data = 1'b1;
    wait_cyc(10);
    exp_fifo.push_back(8'h2A);
    exp_key.push_back({8'h2A, 1'b0, 1'b0});
    send_frame(8'h2A);
    wait_cyc(5);
    rd_pulse();
    wait_cyc(2);
    chk("t6_glitch_empty", valid, 0);

    // Reset mid-frame with a queued byte and a pending F0
    exp_fifo.push_back(8'hF0);
    send_frame(8'hF0);
    wait_cyc(5);
    chk("t6_pre_reset_valid", valid, 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    #1 ps2_clk = 1'b0;
    #23 reset_n = 1'b0;
    #1;
    chk("t6_reset_outputs", {dout, valid, overflow, parity_err, frame_err, key_strobe,
                             key_code, key_ext, key_release}, 32'h0);
    exp_fifo.delete();
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    #1 reset_n = 1'b1;
    wait_cyc(5);
    exp_fifo.push_back(8'h1C);
    exp_key.push_back({8'h1C, 1'b0, 1'b0});
    send_frame(8'h1C);
    wait_cyc(5);
    rd_pulse();
    wait_cyc(50);
    chk("end_fifo_left", exp_fifo.size(), 0);
    chk("end_keys_left", exp_key.size(), 0);
    chk("end_evts_left", exp_evt.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
